l2_bus_arbiter: RTL
===================

// Module: l2_bus_arbiter
// PURPOSE
// - Upstream feeder of the L2 controller request/response channel.
// - Round-robin arbitrates NUM_REQ L1-side requestors onto the single L2 port.
// - Holds one transaction in flight at a time.
// - Routes each L2 read response back to the requestor that issued it.
//   Writes get no response.
// PARAMETERS
// - NUM_REQ  default 4  number of upstream requestors (>=2).
// - IDX_W    default $clog2(NUM_REQ)  grant index width (derived; do not override).
// PORTS  (LA = `ADDR_BITS-`OFFSET_BITS, CL = `CACHELINE_BITS)
// clk            in   1           single clock, rising edge
// reset          in   1           asynchronous, active-high reset
// req_valid      in   NUM_REQ     per-requestor request valid
// req_ready      out  NUM_REQ     per-requestor accept (one-hot or zero)
// req_addr       in   NUM_REQ*LA  line addresses, requestor i in [i*LA +: LA]
// req_rw         in   NUM_REQ     0 read, 1 write
// req_data       in   NUM_REQ*CL  write lines, requestor i in [i*CL +: CL]
// resp_valid     out  NUM_REQ     per-requestor read-response strobe
// resp_data      out  CL          response line, shared by all requestors
// l2_req_valid   out  1           to L2 controller
// l2_req_ready   in   1           L2 controller idle/accepting
// l2_req_addr    out  LA          latched request address
// l2_req_rw      out  1           latched rw
// l2_req_data    out  CL          latched write data
// l2_resp_valid  in   1           L2 read response strobe (1 cycle)
// l2_resp_data   in   CL          L2 read response line
// busy           out  1           state != IDLE
// BEHAVIOUR
// - Reset, asynchronous and active-high:
//   - state=IDLE, last_grant=NUM_REQ-1 (requestor 0 highest priority first).
//   - Latched addr/rw/data=0.
//   - All outputs 0.
//   - Reset mid-transaction drops it silently; no response is produced.
// - FSM states: IDLE, ISSUE, WAIT_RESP.
// - IDLE:
//   - If any req_valid, grant g = first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
//   - req_ready[g]=1 combinationally in that cycle; this is the accept.
//   - Latch g, req_addr[g], req_rw[g], req_data[g]; go to ISSUE.
//   - No req_valid: stay IDLE, req_ready=0.
// - ISSUE:
//   - l2_req_valid=1 with the latched fields.
//   - On l2_req_ready: last_grant<=g.
//     - Write: go to IDLE.
//     - Read: go to WAIT_RESP.
//   - Otherwise hold all fields stable.
// - WAIT_RESP:
//   - l2_req_valid=0.
//   - On l2_resp_valid: resp_valid[g]=1 and resp_data=l2_resp_data, both combinational pass-through for that cycle; go to IDLE.
// - Latency:
//   - Accept-to-l2_req_valid is 1 cycle.
//   - Read response reaches the requestor in the same cycle as l2_resp_valid.
//   - Minimum write turnaround is 2 cycles per request.
// - Responses:
//   - l2_resp_valid outside WAIT_RESP is ignored and never forwarded.
//   - resp_data is 0 when no resp_valid bit is set.
// - Requestor contract: hold req_valid and fields until req_ready.
//   - Dropping valid before grant is allowed; no grant is issued then.
// - Arbitration:
//   - Requests arriving while busy wait; no new accept until the FSM returns to IDLE.
//   - Fairness: a continuously asserting requestor is granted within NUM_REQ transactions.
// - Simultaneous events: a new accept in the same cycle the previous read completes is not allowed; IDLE is entered first.
// - Single-requestor traffic: the same index is re-granted back-to-back.
// STRUCTURE
// - cache.svh: LA/CL macros already shared; add typedef arb_state_t {IDLE, ISSUE, WAIT_RESP} there.
// - Sub-module rr_arbiter #(NUM_REQ) (combinational):
//   - Inputs: req vector, last_grant.
//   - Outputs: gnt_valid, gnt_idx.
//   - Reusable by later multi-port blocks.
// TESTING
// 1. Reset: assert reset mid-ISSUE.
//    -> all outputs 0 next sample, busy=0, no resp_valid ever for the dropped request.
// 2. Single read: req 2 rd addr 0x1A, L2 ready at once, resp 0xDEAD two cycles later.
//    -> req_ready=4'b0100 for 1 cycle, then l2_req_addr=0x1A with rw=0, then resp_valid=4'b0100 with resp_data=0xDEAD.
// 3. Round-robin: all 4 requestors write continuously from reset.
//    -> grant order 0,1,2,3,0; no resp_valid pulses.
// 4. Backpressure: l2_req_ready low for 5 cycles during ISSUE.
//    -> l2_req_valid/addr/rw/data stable for all 5; a single accept follows.
// 5. Spurious response: l2_resp_valid pulsed in IDLE and in ISSUE.
//    -> resp_valid stays 0; FSM state unchanged.
// 6. Mixed traffic: req0 read and req1 write pending together, last_grant=3.
//    -> req0 served first through WAIT_RESP, then req1 write, which gets no response.

Source files
------------

// File: rtl/l2_bus_arbiter_pkg.sv
// Shared widths and state type for the L2 request-channel arbiter.
package l2_bus_arbiter_pkg;

  localparam int ADDR_BITS      = 32;
  localparam int OFFSET_BITS    = 6;
  localparam int CACHELINE_BITS = 64;

  // Line-address and cache-line widths carried on the request channel.
  localparam int LA = ADDR_BITS - OFFSET_BITS;
  localparam int CL = CACHELINE_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/l2_bus_arbiter_if.sv
// Requestor-side and L2-side bus bundle for l2_bus_arbiter.
// master: the arbiter's view; slave: the surrounding requestors and L2 controller.
interface l2_bus_arbiter_if #(parameter int NUM_REQ = 4) ();
  import l2_bus_arbiter_pkg::*;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*LA-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_rw;
  logic [NUM_REQ*CL-1:0] req_data;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [CL-1:0]         resp_data;
  logic                  l2_req_valid;
  logic                  l2_req_ready;
  logic [LA-1:0]         l2_req_addr;
  logic                  l2_req_rw;
  logic [CL-1:0]         l2_req_data;
  logic                  l2_resp_valid;
  logic [CL-1:0]         l2_resp_data;
  logic                  busy;

  modport master (
    input  req_valid, req_addr, req_rw, req_data,
    input  l2_req_ready, l2_resp_valid, l2_resp_data,
    output req_ready, resp_valid, resp_data,
    output l2_req_valid, l2_req_addr, l2_req_rw, l2_req_data, busy
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_data,
    output l2_req_ready, l2_resp_valid, l2_resp_data,
    input  req_ready, resp_valid, resp_data,
    input  l2_req_valid, l2_req_addr, l2_req_rw, l2_req_data, busy
  );

endinterface

// File: rtl/l2_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after last_grant, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest set request wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin feeder of the single L2 request port; one transaction in flight,
// read responses routed back to the issuing requestor.
module l2_bus_arbiter
  import l2_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input logic              clk,
  input logic              reset,
  l2_bus_arbiter_if.master bus
);

  arb_state_t       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gidx;
  logic [LA-1:0]    lat_addr;
  logic             lat_rw;
  logic [CL-1:0]    lat_data;
  logic             l2_valid_q;
  logic             busy_q;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [LA-1:0]    sel_addr;
  logic             sel_rw;
  logic [CL-1:0]    sel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // Mux the winning requestor's fields out of the flattened buses.
  always_comb begin
    sel_addr = '0;
    sel_rw   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr = bus.req_addr[i*LA +: LA];
        sel_rw   = bus.req_rw[i];
        sel_data = bus.req_data[i*CL +: CL];
      end
    end
  end

  // Transaction FSM; last_grant only advances once L2 has taken the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      gidx       <= '0;
      lat_addr   <= '0;
      lat_rw     <= 1'b0;
      lat_data   <= '0;
      l2_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gidx       <= gnt_idx;
            lat_addr   <= sel_addr;
            lat_rw     <= sel_rw;
            lat_data   <= sel_data;
            l2_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.l2_req_ready) begin
            last_grant <= gidx;
            l2_valid_q <= 1'b0;
            if (lat_rw) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (bus.l2_resp_valid) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          l2_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // Same-cycle accept and response pass-through; a response seen outside WAIT_RESP is dropped.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.resp_data  = '0;
    if (!reset && state == IDLE && gnt_valid) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
    if (state == WAIT_RESP && bus.l2_resp_valid) begin
      bus.resp_valid[gidx] = 1'b1;
      bus.resp_data        = bus.l2_resp_data;
    end
  end

  assign bus.l2_req_valid = l2_valid_q;
  assign bus.l2_req_addr  = lat_addr;
  assign bus.l2_req_rw    = lat_rw;
  assign bus.l2_req_data  = lat_data;
  assign bus.busy         = busy_q;

endmodule
